fq_writer: RTL and testbench

FQ_WRITER -- requirements
Module: fq_writer

---
 rtl/iommu_pkg.sv | 45 ++++
 rtl/fq_writer.sv | 152 +++++++++++++++
 tb/tb_fq_writer.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iommu_pkg.sv
// Shared IOMMU definitions: the 256-bit fault-queue record layout and the
// CAUSE / TTYP encodings used when building records.
package iommu_pkg;

   typedef struct packed {
      logic [63:0] iotval2;
      logic [63:0] iotval;
      logic [31:0] rsvd;
      logic [31:0] custom;
      logic [23:0] did;
      logic [5:0]  ttyp;
      logic        priv;
      logic        pv;
      logic [19:0] pid;
      logic [11:0] cause;
   } fq_record_t;

   localparam logic [11:0] CAUSE_INST_ACCESS_FAULT     = 12'd1;
   localparam logic [11:0] CAUSE_LOAD_ADDR_MISALIGNED  = 12'd4;
   localparam logic [11:0] CAUSE_LOAD_ACCESS_FAULT     = 12'd5;
   localparam logic [11:0] CAUSE_STORE_ADDR_MISALIGNED = 12'd6;
   localparam logic [11:0] CAUSE_STORE_ACCESS_FAULT    = 12'd7;
   localparam logic [11:0] CAUSE_INST_PAGE_FAULT       = 12'd12;
   localparam logic [11:0] CAUSE_LOAD_PAGE_FAULT       = 12'd13;
   localparam logic [11:0] CAUSE_STORE_PAGE_FAULT      = 12'd15;
   localparam logic [11:0] CAUSE_INST_GUEST_PAGE_FAULT = 12'd20;
   localparam logic [11:0] CAUSE_LOAD_GUEST_PAGE_FAULT = 12'd21;
   localparam logic [11:0] CAUSE_STORE_GUEST_PAGE_FAULT = 12'd23;
   localparam logic [11:0] CAUSE_ALL_INB_DISALLOWED    = 12'd256;
   localparam logic [11:0] CAUSE_DDT_LOAD_FAULT        = 12'd257;
   localparam logic [11:0] CAUSE_DDT_ENTRY_INVALID     = 12'd258;
   localparam logic [11:0] CAUSE_DDT_MISCONFIGURED     = 12'd259;
   localparam logic [11:0] CAUSE_TTYP_DISALLOWED       = 12'd260;

   localparam logic [5:0] TTYP_NONE          = 6'd0;
   localparam logic [5:0] TTYP_UADDR_RD_EXEC = 6'd1;
   localparam logic [5:0] TTYP_UADDR_RD      = 6'd2;
   localparam logic [5:0] TTYP_UADDR_WR      = 6'd3;
   localparam logic [5:0] TTYP_TADDR_RD_EXEC = 6'd5;
   localparam logic [5:0] TTYP_TADDR_RD      = 6'd6;
   localparam logic [5:0] TTYP_TADDR_WR      = 6'd7;
   localparam logic [5:0] TTYP_PCIE_ATS_REQ  = 6'd8;
   localparam logic [5:0] TTYP_PCIE_MSG_REQ  = 6'd9;

endpackage

// File: rtl/fq_writer.sv
// Fault-queue writer: accepts one fault record at a time and writes it as
// four 64-bit beats to the in-memory circular queue, then advances the tail.
module fq_writer
   import iommu_pkg::*;
#(
   parameter int unsigned ADDR_W = 56
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              fq_en_i,
   input  logic [43:0]       fq_ppn_i,
   input  logic [4:0]        fq_log2szm1_i,
   input  logic [31:0]       fq_head_i,
   input  logic              fault_valid_i,
   output logic              fault_ready_o,
   input  logic [255:0]      fault_rec_i,
   output logic              mem_req_o,
   input  logic              mem_gnt_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [63:0]       mem_wdata_o,
   output logic              mem_last_o,
   input  logic              mem_rsp_valid_i,
   input  logic              mem_rsp_err_i,
   output logic [31:0]       fq_tail_o,
   output logic              fq_on_o,
   output logic              fqof_o,
   output logic              fqmf_o,
   output logic              fip_o,
   input  logic              fqof_clr_i,
   input  logic              fqmf_clr_i,
   input  logic              fip_clr_i
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_RESP  = 2'd2
   } fq_writer_state_e;

   fq_writer_state_e state_q, state_d;
   logic [1:0]       beat_q, beat_d;
   logic [31:0]      tail_q, tail_d;
   fq_record_t       rec_q, rec_d;
   logic             fq_on_q;
   logic             fqof_q, fqof_d;
   logic             fqmf_q, fqmf_d;
   logic             fip_q, fip_d;

   logic             ready;
   logic             ofSet, mfSet, ipSet;
   logic [31:0]      sizeMask;
   logic [31:0]      tailInc;
   logic             full;

   // Queue holds 2^(log2szm1+1) entries, so the index mask is that many low ones.
   assign sizeMask = 32'hFFFF_FFFF >> (5'd31 - fq_log2szm1_i);
   assign tailInc  = (tail_q + 32'd1) & sizeMask;
   assign full     = (tailInc == (fq_head_i & sizeMask));

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      tail_d    = tail_q;
      rec_d     = rec_q;
      ofSet     = 1'b0;
      mfSet     = 1'b0;
      ipSet     = 1'b0;
      ready     = (state_q == S_IDLE) && fq_on_q && fq_en_i;
      mem_req_o = 1'b0;
      mem_last_o = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (fault_valid_i && ready) begin
               rec_d = fq_record_t'(fault_rec_i);
               if (full) begin
                  ofSet = 1'b1;
               end else if (!fqof_q && !fqmf_q) begin
                  state_d = S_WRITE;
                  beat_d  = 2'd0;
               end
            end
         end
         S_WRITE: begin
            mem_req_o  = 1'b1;
            mem_last_o = (beat_q == 2'd3);
            if (mem_gnt_i) begin
               beat_d = beat_q + 2'd1;
               if (beat_q == 2'd3) begin
                  state_d = S_RESP;
               end
            end
         end
         S_RESP: begin
            if (mem_rsp_valid_i) begin
               state_d = S_IDLE;
               if (mem_rsp_err_i) begin
                  mfSet = 1'b1;
               end else if (fq_en_i) begin
                  tail_d = tailInc;
                  ipSet  = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A disabled queue always restarts from index 0, even mid-record.
      if (!fq_en_i) begin
         tail_d = '0;
      end

      fqof_d = ofSet | (fqof_q & ~fqof_clr_i);
      fqmf_d = mfSet | (fqmf_q & ~fqmf_clr_i);
      fip_d  = ipSet | (fip_q & ~fip_clr_i);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         tail_q  <= '0;
         rec_q   <= '0;
         fq_on_q <= 1'b0;
         fqof_q  <= 1'b0;
         fqmf_q  <= 1'b0;
         fip_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         tail_q  <= tail_d;
         rec_q   <= rec_d;
         fq_on_q <= fq_en_i;
         fqof_q  <= fqof_d;
         fqmf_q  <= fqmf_d;
         fip_q   <= fip_d;
      end
   end

   assign fault_ready_o = ready;
   assign mem_addr_o    = ADDR_W'({fq_ppn_i, 12'h000}) + ADDR_W'({tail_q, 5'b00000})
                        + ADDR_W'({beat_q, 3'b000});
   assign mem_wdata_o   = rec_q[64*beat_q +: 64];
   assign fq_tail_o     = tail_q;
   assign fq_on_o       = fq_on_q;
   assign fqof_o        = fqof_q;
   assign fqmf_o        = fqmf_q;
   assign fip_o         = fip_q;

endmodule

// File: tb/tb_fq_writer.sv
// Directed bench for fq_writer: each task drives one scenario and compares
// DUT outputs against hand-computed values.
module tb_fq_writer;
   import iommu_pkg::*;

   logic         clock = 1'b0;
   logic         rstN;
   logic         fqEn;
   logic [43:0]  fqPpn;
   logic [4:0]   fqLog2;
   logic [31:0]  fqHead;
   logic         faultValid;
   logic         faultReady;
   logic [255:0] faultRec;
   logic         memReq;
   logic         memGnt;
   logic [55:0]  memAddr;
   logic [63:0]  memWdata;
   logic         memLast;
   logic         memRspValid;
   logic         memRspErr;
   logic [31:0]  fqTail;
   logic         fqOn;
   logic         fqof;
   logic         fqmf;
   logic         fip;
   logic         fqofClr;
   logic         fqmfClr;
   logic         fipClr;

   int nChecks = 0;
   int nPassed = 0;

   logic [63:0] words [4];
   logic [255:0] recA;

   fq_writer #(.ADDR_W(56)) dut (
      .clk_i           (clock),
      .rst_ni          (rstN),
      .fq_en_i         (fqEn),
      .fq_ppn_i        (fqPpn),
      .fq_log2szm1_i   (fqLog2),
      .fq_head_i       (fqHead),
      .fault_valid_i   (faultValid),
      .fault_ready_o   (faultReady),
      .fault_rec_i     (faultRec),
      .mem_req_o       (memReq),
      .mem_gnt_i       (memGnt),
      .mem_addr_o      (memAddr),
      .mem_wdata_o     (memWdata),
      .mem_last_o      (memLast),
      .mem_rsp_valid_i (memRspValid),
      .mem_rsp_err_i   (memRspErr),
      .fq_tail_o       (fqTail),
      .fq_on_o         (fqOn),
      .fqof_o          (fqof),
      .fqmf_o          (fqmf),
      .fip_o           (fip),
      .fqof_clr_i      (fqofClr),
      .fqmf_clr_i      (fqmfClr),
      .fip_clr_i       (fipClr)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Offer one record and complete it with immediate grants and one response.
   task automatic run_record(input logic [255:0] rec, input logic err);
      faultRec   = rec;
      faultValid = 1'b1;
      step();
      faultValid = 1'b0;
      memGnt     = 1'b1;
      for (int k = 0; k < 4; k++) step();
      memGnt      = 1'b0;
      memRspValid = 1'b1;
      memRspErr   = err;
      step();
      memRspValid = 1'b0;
      memRspErr   = 1'b0;
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      fqEn = 1'b0;
      step();
      step();
      nChecks++;
      if (faultReady !== 1'b0) $display("[TB] FAIL reset_ready: got %b want 0", faultReady); else nPassed++;
      nChecks++;
      if (memReq !== 1'b0) $display("[TB] FAIL reset_req: got %b want 0", memReq); else nPassed++;
      nChecks++;
      if (memLast !== 1'b0) $display("[TB] FAIL reset_last: got %b want 0", memLast); else nPassed++;
      nChecks++;
      if (fqTail !== 32'd0) $display("[TB] FAIL reset_tail: got %0d want 0", fqTail); else nPassed++;
      nChecks++;
      if ({fqOn, fqof, fqmf, fip} !== 4'b0000)
         $display("[TB] FAIL reset_flags: got %b want 0000", {fqOn, fqof, fqmf, fip});
      else nPassed++;
      rstN = 1'b1;
      step();
      nChecks++;
      if ({faultReady, fqOn} !== 2'b00)
         $display("[TB] FAIL disabled_idle: got %b want 00", {faultReady, fqOn});
      else nPassed++;
   endtask

   task automatic test_enable();
      fqEn = 1'b1;
      #1;
      nChecks++;
      if (fqOn !== 1'b0) $display("[TB] FAIL enable_early: got %b want 0", fqOn); else nPassed++;
      step();
      nChecks++;
      if (fqOn !== 1'b1) $display("[TB] FAIL enable_on: got %b want 1", fqOn); else nPassed++;
      nChecks++;
      if ({faultReady, fqTail} !== {1'b1, 32'd0})
         $display("[TB] FAIL enable_ready_tail: got %b/%0d want 1/0", faultReady, fqTail);
      else nPassed++;
   endtask

   task automatic test_basic_write();
      fqPpn  = 44'h80000;
      fqLog2 = 5'd3;
      fqHead = 32'd0;
      faultRec   = recA;
      faultValid = 1'b1;
      step();
      faultValid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         nChecks++;
         if (memReq !== 1'b1 || memAddr !== 56'h8000_0000 + 56'(k * 8))
            $display("[TB] FAIL beat%0d_addr: got req=%b addr=%h want req=1 addr=%h",
                     k, memReq, memAddr, 56'h8000_0000 + 56'(k * 8));
         else nPassed++;
         nChecks++;
         if (memWdata !== words[k])
            $display("[TB] FAIL beat%0d_data: got %h want %h", k, memWdata, words[k]);
         else nPassed++;
         nChecks++;
         if (memLast !== (k == 3))
            $display("[TB] FAIL beat%0d_last: got %b want %b", k, memLast, (k == 3));
         else nPassed++;
         if (k == 0) begin
            nChecks++;
            if (memWdata[11:0] !== CAUSE_LOAD_PAGE_FAULT)
               $display("[TB] FAIL word0_cause: got %0d want 13", memWdata[11:0]);
            else nPassed++;
         end
         memGnt = 1'b1;
         step();
         memGnt = 1'b0;
      end
      nChecks++;
      if ({memReq, faultReady} !== 2'b00)
         $display("[TB] FAIL resp_wait: got req/ready=%b want 00", {memReq, faultReady});
      else nPassed++;
      memRspValid = 1'b1;
      step();
      memRspValid = 1'b0;
      nChecks++;
      if (fqTail !== 32'd1) $display("[TB] FAIL basic_tail: got %0d want 1", fqTail); else nPassed++;
      nChecks++;
      if ({fip, faultReady} !== 2'b11)
         $display("[TB] FAIL basic_fip_ready: got %b want 11", {fip, faultReady});
      else nPassed++;
   endtask

   task automatic test_mem_error();
      fipClr = 1'b1;
      step();
      fipClr = 1'b0;
      nChecks++;
      if (fip !== 1'b0) $display("[TB] FAIL fip_clear: got %b want 0", fip); else nPassed++;
      run_record(recA, 1'b1);
      nChecks++;
      if (fqmf !== 1'b1) $display("[TB] FAIL memerr_fqmf: got %b want 1", fqmf); else nPassed++;
      nChecks++;
      if (fqTail !== 32'd1) $display("[TB] FAIL memerr_tail: got %0d want 1", fqTail); else nPassed++;
      nChecks++;
      if (fip !== 1'b0) $display("[TB] FAIL memerr_fip: got %b want 0", fip); else nPassed++;
      fqmfClr = 1'b1;
      step();
      fqmfClr = 1'b0;
      nChecks++;
      if (fqmf !== 1'b0) $display("[TB] FAIL fqmf_clear: got %b want 0", fqmf); else nPassed++;
   endtask

   task automatic test_overflow();
      run_record(recA, 1'b0);
      fqHead = 32'd3;
      nChecks++;
      if (fqTail !== 32'd2) $display("[TB] FAIL ovf_setup_tail: got %0d want 2", fqTail); else nPassed++;
      faultValid = 1'b1;
      step();
      faultValid = 1'b0;
      nChecks++;
      if ({fqof, memReq, faultReady} !== 3'b101)
         $display("[TB] FAIL ovf_drop: got of/req/ready=%b want 101", {fqof, memReq, faultReady});
      else nPassed++;
      fqHead = 32'd0;
      faultValid = 1'b1;
      step();
      faultValid = 1'b0;
      step();
      nChecks++;
      if ({memReq, fqTail} !== {1'b0, 32'd2})
         $display("[TB] FAIL ovf_sticky_drop: got req=%b tail=%0d want 0/2", memReq, fqTail);
      else nPassed++;
      fqofClr = 1'b1;
      step();
      fqofClr = 1'b0;
      nChecks++;
      if (fqof !== 1'b0) $display("[TB] FAIL fqof_clear: got %b want 0", fqof); else nPassed++;
      run_record(recA, 1'b0);
      nChecks++;
      if (fqTail !== 32'd3) $display("[TB] FAIL ovf_resume_tail: got %0d want 3", fqTail); else nPassed++;
      fqHead     = 32'd4;
      faultValid = 1'b1;
      fqofClr    = 1'b1;
      step();
      faultValid = 1'b0;
      fqofClr    = 1'b0;
      nChecks++;
      if (fqof !== 1'b1) $display("[TB] FAIL set_over_clear: got %b want 1", fqof); else nPassed++;
      fqofClr = 1'b1;
      step();
      fqofClr = 1'b0;
   endtask

   task automatic test_wrap();
      int modelTail = 3;
      while (modelTail != 15) begin
         fqHead = 32'((modelTail + 8) & 15);
         run_record(recA, 1'b0);
         modelTail++;
      end
      nChecks++;
      if (fqTail !== 32'd15) $display("[TB] FAIL wrap_pre_tail: got %0d want 15", fqTail); else nPassed++;
      fqHead = 32'd5;
      run_record(recA, 1'b0);
      nChecks++;
      if (fqTail !== 32'd0) $display("[TB] FAIL wrap_tail: got %0d want 0", fqTail); else nPassed++;
   endtask

   task automatic test_stall_and_reset();
      fqHead     = 32'd8;
      faultRec   = recA;
      faultValid = 1'b1;
      step();
      faultValid = 1'b0;
      memGnt     = 1'b1;
      step();
      memGnt     = 1'b0;
      for (int c = 0; c < 5; c++) begin
         nChecks++;
         if ({memReq, memAddr, memWdata} !== {1'b1, 56'h8000_0008, words[1]})
            $display("[TB] FAIL stall_c%0d: got req=%b addr=%h data=%h want 1/80000008/%h",
                     c, memReq, memAddr, memWdata, words[1]);
         else nPassed++;
         step();
      end
      memGnt = 1'b1;
      step();
      memGnt = 1'b0;
      rstN   = 1'b0;
      step();
      nChecks++;
      if ({memReq, memLast, faultReady} !== 3'b000)
         $display("[TB] FAIL midreset_mem: got req/last/ready=%b want 000", {memReq, memLast, faultReady});
      else nPassed++;
      nChecks++;
      if ({fqTail, fqOn, fqof, fqmf, fip} !== {32'd0, 4'b0000})
         $display("[TB] FAIL midreset_state: got tail=%0d flags=%b want 0/0000",
                  fqTail, {fqOn, fqof, fqmf, fip});
      else nPassed++;
      rstN = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         nChecks++;
         if (memReq !== 1'b0) $display("[TB] FAIL postreset_req%0d: got %b want 0", c, memReq); else nPassed++;
      end
   endtask

   initial begin
      words[0] = 64'h0000_0001_0000_000D;
      words[1] = 64'h1111_2222_3333_4444;
      words[2] = 64'hDEAD_BEEF_0000_1000;
      words[3] = 64'h0000_0000_CAFE_F00D;
      recA = {words[3], words[2], words[1], words[0]};

      rstN        = 1'b0;
      fqEn        = 1'b0;
      fqPpn       = 44'h80000;
      fqLog2      = 5'd3;
      fqHead      = 32'd0;
      faultValid  = 1'b0;
      faultRec    = '0;
      memGnt      = 1'b0;
      memRspValid = 1'b0;
      memRspErr   = 1'b0;
      fqofClr     = 1'b0;
      fqmfClr     = 1'b0;
      fipClr      = 1'b0;

      test_reset();
      test_enable();
      test_basic_write();
      test_mem_error();
      test_overflow();
      test_wrap();
      test_stall_and_reset();

      $display("%0d/%0d checks passed", nPassed, nChecks);
      $finish;
   end

endmodule
